pipe_cla_addsub: RTL and testbench
==================================

PIPE_CLA_ADDSUB -- requirements
Module: pipe_cla_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; legal values are multiples of 4, from 4 to 64.
REQ-002 SHALL derive GROUPS = WIDTH/4, the number of 4-bit lookahead groups and pipeline stages.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port a, input, WIDTH bits: operand A.
REQ-006 SHALL have port b, input, WIDTH bits: operand B.
REQ-007 SHALL have port cin, input, 1 bit: carry-in; used in add mode only.
REQ-008 SHALL have port sub, input, 1 bit: 0 = add, 1 = subtract.
REQ-009 SHALL have port in_valid, input, 1 bit; and port in_ready, output, 1 bit: input handshake.
REQ-010 SHALL have port sum, output, WIDTH bits: result.
REQ-011 SHALL have port cout, output, 1 bit: carry-out; in subtract mode, 1 = no borrow.
REQ-012 SHALL have port ovf, output, 1 bit: two's-complement signed overflow.
REQ-013 SHALL have port zero, output, 1 bit: 1 when sum == 0.
REQ-014 SHALL have port out_valid, output, 1 bit; and port out_ready, input, 1 bit: output handshake.

Function
REQ-015 SHALL compute a + b + cin when sub=0, and a + ~b + 1 when sub=1; cin is ignored in subtract mode.
REQ-016 SHALL implement each 4-bit group as a full carry-lookahead unit: g=a&b, p=a^b, and every group carry expanded from g, p and the group carry-in with no internal ripple.
REQ-017 SHALL place group k (bits 4k+3..4k) in pipeline stage k, registering the group carry-out into stage k+1; operand slices for groups above k SHALL travel with the transaction.
REQ-018 SHALL have a latency of exactly GROUPS cycles, from the in_valid&&in_ready edge to out_valid, with no pipeline stalls.
REQ-019 SHALL sustain a throughput of one transaction per cycle while out_ready=1.
REQ-020 SHALL stall the whole pipeline when out_valid=1 and out_ready=0: no stage advances, and all outputs hold stable.
REQ-021 SHALL drive in_ready = !(out_valid && !out_ready), combinationally.
REQ-022 SHALL treat a transfer as occurring only on a cycle with valid && ready; a bubble SHALL advance through the pipeline like data.
REQ-023 SHALL compute ovf = carry-into-MSB XOR carry-out-of-MSB, and cout = final carry.
REQ-024 SHALL compute zero from the final (post-saturation) sum.
REQ-025 SHALL allow in_valid to be deasserted at any time with no effect on in-flight data; transactions SHALL never reorder or be dropped.
REQ-026 SHALL register sum, cout, ovf, zero and out_valid; there SHALL be no combinational path from a or b to any output.

Reset
REQ-027 SHALL clear out_valid and every stage valid to 0 on a clock edge with rst_n=0.
REQ-028 SHALL reset sum, cout, ovf and zero to 0.
REQ-029 SHALL discard in-flight transactions when reset is asserted mid-operation; the first accepted input after reset SHALL appear after GROUPS cycles.
REQ-030 SHALL keep in_ready at 1 during and after reset, because out_valid=0.

Configuration
REQ-031 SHALL, when macro PIPE_CLA_SAT_EN is defined, clamp sum on ovf=1 to 0 followed by WIDTH-1 ones for positive overflow, or 1 followed by WIDTH-1 zeros for negative overflow; ovf and cout SHALL report the raw, unsaturated values.
REQ-032 SHALL, without PIPE_CLA_SAT_EN, wrap sum modulo 2^WIDTH; the remaining behaviour is identical.

Verification (WIDTH=16 unless stated)
REQ-033 SHALL cover: a=0x1234, b=0x4321, cin=1, sub=0 -> sum=0x5556, cout=0, ovf=0, zero=0, out_valid exactly 4 cycles after acceptance.
REQ-034 SHALL cover: a=0x7FFF, b=0x0001, sub=0 -> ovf=1, cout=0; sum=0x8000 without the macro, sum=0x7FFF with PIPE_CLA_SAT_EN.
REQ-035 SHALL cover: a=0x0005, b=0x0005, sub=1 -> sum=0, zero=1, cout=1; and a=0x0000, b=0x0001, sub=1 -> sum=0xFFFF, cout=0, ovf=0.
REQ-036 SHALL cover: 8 back-to-back inputs, with out_ready held low for 3 cycles after the first out_valid -> in_ready=0 during the hold, outputs stable, all 8 results delivered in order with none lost.
REQ-037 SHALL cover: rst_n=0 for 1 cycle while 3 transactions are in flight -> out_valid=0 on the next cycle, and no stale results are emitted afterwards.
REQ-038 SHALL cover: WIDTH=4, a=0xF, b=0x1, cin=0 -> sum=0x0, cout=1, zero=1, latency 1 cycle.

Source files
------------

// File: rtl/pipe_cla_addsub.sv
// Pipelined adder/subtractor: one 4-bit carry-lookahead group per stage, valid/ready handshake.
// Optional macro PIPE_CLA_SAT_EN saturates the sum on signed overflow (ovf/cout stay raw).
module pipe_cla_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int GROUPS = WIDTH / 4;

  // Returns {c4, c3, c2, c1, c0}; every carry is a flat sum of products.
  function automatic logic [4:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic c0);
    logic [4:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  // A wrapped result with MSB set means the true value was positive.
  function automatic logic [WIDTH-1:0] saturate(input logic signed [WIDTH-1:0] raw, input logic ov);
    logic signed [WIDTH-1:0] smax;
    logic signed [WIDTH-1:0] smin;
    smax = {1'b0, {(WIDTH-1){1'b1}}};
    smin = ~smax;
    if (!ov) return raw;
    return raw[WIDTH-1] ? smax : smin;
  endfunction

  logic adv;

  assign in_ready = !(out_valid && !out_ready);
  assign adv      = in_ready;

  for (genvar k = 0; k < GROUPS; k++) begin : g_stage
    localparam int IW = WIDTH - 4*k;

    logic [IW-1:0]  a_in;
    logic [IW-1:0]  b_in;
    logic           c_in;
    logic           v_in;
    logic [4*k+3:0] s_nx;
    logic [3:0]     p4;
    logic [3:0]     g4;
    logic [4:0]     cl;
    logic [3:0]     gs;

    if (k == 0) begin : g_src
      assign a_in = a;
      assign b_in = b ^ {WIDTH{sub}};
      assign c_in = sub | cin;
      assign v_in = in_valid;
      assign s_nx = gs;
    end else begin : g_src
      assign a_in = g_stage[k-1].g_reg.a_q;
      assign b_in = g_stage[k-1].g_reg.b_q;
      assign c_in = g_stage[k-1].g_reg.c_q;
      assign v_in = g_stage[k-1].g_reg.v_q;
      assign s_nx = {gs, g_stage[k-1].g_reg.s_q};
    end

    assign g4 = a_in[3:0] & b_in[3:0];
    assign p4 = a_in[3:0] ^ b_in[3:0];
    assign cl = cla4(g4, p4, c_in);
    assign gs = p4 ^ cl[3:0];

    if (k < GROUPS-1) begin : g_reg
      logic [IW-5:0]  a_q;
      logic [IW-5:0]  b_q;
      logic [4*k+3:0] s_q;
      logic           c_q;
      logic           v_q;

      always_ff @(posedge clk) begin
        if (!rst_n)   v_q <= 1'b0;
        else if (adv) v_q <= v_in;
      end

      // ---- stage k -> k+1: unconsumed operand slices, low sum bits, group carry
      always_ff @(posedge clk) begin
        if (adv) begin
          a_q <= a_in[IW-1:4];
          b_q <= b_in[IW-1:4];
          s_q <= s_nx;
          c_q <= cl[4];
        end
      end
    end else begin : g_out
      logic             ovf_nx;
      logic [WIDTH-1:0] fin;

      assign ovf_nx = cl[4] ^ cl[3];
`ifdef PIPE_CLA_SAT_EN
      assign fin = saturate(s_nx, ovf_nx);
`else
      assign fin = s_nx;
`endif

      // ---- final stage -> output registers
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          sum       <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
          zero      <= 1'b0;
        end else if (adv) begin
          out_valid <= v_in;
          sum       <= fin;
          cout      <= cl[4];
          ovf       <= ovf_nx;
          zero      <= (fin == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Bench for pipe_cla_addsub: WIDTH=16 instance checked against an arithmetic scoreboard every
// cycle, plus directed literal vectors on WIDTH=16 and WIDTH=4 instances.
module tb_pipe_cla_addsub;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] a, b;
  logic        cin, sub, in_valid, in_ready, out_ready;
  logic [15:0] sum;
  logic        cout, ovf, zero, out_valid;

  logic [3:0]  a4, b4, s4;
  logic        cin4, sub4, iv4, ir4, co4, ov4, z4, ovd4, ordy4;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_deliv  = 0;
  res_t q[$];

  pipe_cla_addsub #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .sub(sub),
    .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .cout(cout), .ovf(ovf),
    .zero(zero), .out_valid(out_valid), .out_ready(out_ready)
  );

  pipe_cla_addsub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .in_valid(iv4), .in_ready(ir4), .sum(s4), .cout(co4), .ovf(ov4),
    .zero(z4), .out_valid(ovd4), .out_ready(ordy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Plain integer arithmetic; overflow from operand/result signs.
  function automatic res_t model16(input logic [15:0] x, input logic [15:0] y,
                                   input logic ci, input logic s);
    res_t        r;
    logic [15:0] ye;
    logic [16:0] full;
    ye     = s ? ~y : y;
    full   = {1'b0, x} + {1'b0, ye} + {16'd0, (s ? 1'b1 : ci)};
    r.cout = full[16];
    r.ovf  = (x[15] == ye[15]) && (full[15] != x[15]);
    r.sum  = full[15:0];
`ifdef PIPE_CLA_SAT_EN
    if (r.ovf) r.sum = x[15] ? 16'h8000 : 16'h7FFF;
`endif
    r.zero = (r.sum == 16'h0000);
    return r;
  endfunction

  // Scoreboard: decide at negedge what the coming posedge will transfer.
  always @(negedge clk) begin
    chk("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL stale_output: got sum %0h with no transaction outstanding", sum);
        end else begin
          chk("sb_sum",  64'(sum),  64'(q[0].sum));
          chk("sb_cout", 64'(cout), 64'(q[0].cout));
          chk("sb_ovf",  64'(ovf),  64'(q[0].ovf));
          chk("sb_zero", 64'(zero), 64'(q[0].zero));
          if (out_ready) begin
            void'(q.pop_front());
            n_deliv++;
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model16(a, b, cin, sub));
    end
  end

  task automatic run_one16(input string nm, input logic [15:0] x, input logic [15:0] y,
                           input logic ci, input logic s, input logic [15:0] es,
                           input logic ec, input logic eo, input logic ez, input int elat);
    int lat;
    a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_lat"},  64'(lat),  64'(elat));
    chk({nm, "_sum"},  64'(sum),  64'(es));
    chk({nm, "_cout"}, 64'(cout), 64'(ec));
    chk({nm, "_ovf"},  64'(ovf),  64'(eo));
    chk({nm, "_zero"}, 64'(zero), 64'(ez));
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((q.size() != 0 || out_valid) && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    chk({nm, "_drained"}, 64'(q.size()), 64'd0);
  endtask

  logic [15:0] va [8] = '{16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h1234, 16'hA5A5, 16'h0F0F, 16'h8001};
  logic [15:0] vb [8] = '{16'hFFFF, 16'h0001, 16'h8000, 16'hFFFF, 16'hEDCC, 16'h5A5A, 16'hF0F0, 16'h0002};

  initial begin
    int          lat4, base, t;
    logic [15:0] hs;
    logic        hc, ho, hz;

    rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0; iv4 = 1'b0; ordy4 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum",       64'(sum),       64'd0);
    chk("rst_flags",     64'({cout, ovf, zero}), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_w4_valid",  64'(ovd4),      64'd0);
    chk("rst_w4_sum",    64'(s4),        64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_one16("add_basic",  16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0, 4);
`ifdef PIPE_CLA_SAT_EN
    run_one16("pos_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 4);
    run_one16("neg_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 4);
`else
    run_one16("pos_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 4);
    run_one16("neg_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 4);
`endif
    run_one16("sub_zero",   16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 4);
    run_one16("sub_cin_ig", 16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 4);
    run_one16("sub_borrow", 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4);
    run_one16("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4);
    drain("directed");

    // WIDTH=4 single-stage instance
    a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0; sub4 = 1'b0; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    lat4 = 1;
    while (!ovd4 && lat4 < 10) begin
      @(posedge clk); #1;
      lat4++;
    end
    chk("w4_lat",  64'(lat4), 64'd1);
    chk("w4_sum",  64'(s4),   64'h0);
    chk("w4_cout", 64'(co4),  64'd1);
    chk("w4_zero", 64'(z4),   64'd1);
    chk("w4_ovf",  64'(ov4),  64'd0);

    // streaming with bubbles, full-rate otherwise
    for (int i = 0; i < 12; i++) begin
      a = va[i % 8]; b = vb[i % 8]; cin = i[0]; sub = i[2];
      in_valid = (i % 3 != 2);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain("stream");

    // 8 back-to-back with a 3-cycle output hold
    base = n_deliv;
    fork
      begin : drv
        int  i;
        logic acc;
        i = 0;
        while (i < 8) begin
          a = va[i] ^ 16'h0A0A; b = vb[i]; cin = i[0]; sub = i[1]; in_valid = 1'b1;
          @(negedge clk);
          acc = in_ready;
          @(posedge clk); #1;
          if (acc) i++;
        end
        in_valid = 1'b0;
      end
      begin : hold
        int w;
        w = 0;
        while (!out_valid && w < 40) begin
          @(posedge clk); #1;
          w++;
        end
        chk("b2b_first_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        hs = sum; hc = cout; ho = ovf; hz = zero;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("hold_in_ready", 64'(in_ready),  64'd0);
          chk("hold_valid",    64'(out_valid), 64'd1);
          chk("hold_stable",   64'({sum, cout, ovf, zero}), 64'({hs, hc, ho, hz}));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("b2b");
    chk("b2b_delivered", 64'(n_deliv - base), 64'd8);

    // reset with 3 transactions in flight
    for (int i = 0; i < 3; i++) begin
      a = va[i]; b = vb[i]; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_sum",   64'(sum),       64'd0);
    t = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid) t++;
    end
    chk("midrst_no_stale", 64'(t), 64'd0);
    run_one16("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 4);
    drain("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
